// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB subsystem types and constants
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;
  // Address bit decoded upstream into PSEL for the two completers
  localparam int SEL_BIT    = 8;

endpackage

// File: rtl/apb_slave_mem_array.sv
// rtl/apb_slave_mem_array.sv - DEPTH x DATA_WIDTH storage, async clear, 1W/1R
module apb_slave_mem_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  raddr_ok;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Unimplemented words read as zero rather than X
  assign raddr_ok = ({{(32-ADDR_WIDTH){1'b0}}, raddr} < 32'(DEPTH));
  assign rdata    = raddr_ok ? mem[raddr] : '0;

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer with wait states, range errors and protocol checks
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  proto_err,
  input  logic                  clr_err
);

  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  proto_err_q, proto_err_d;
  logic                  proto_set;
  logic                  mem_we;
  logic                  addr_err;
  logic                  violation;

  apb_slave_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .we     (mem_we),
    .waddr  (addr_q),
    .wdata  (wdata_q),
    .raddr  (PADDR),
    .rdata  (rd_word)
  );

  assign addr_err = ({{(32-ADDR_WIDTH){1'b0}}, PADDR} >= 32'(DEPTH));

  // The master must hold the whole transfer stable until PREADY
  assign violation = !PSEL || !PENABLE || (PADDR != addr_q) || (PWRITE != write_q)
                     || (write_q && (PWDATA != wdata_q));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    prdata_d  = prdata_q;
    proto_set = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d  = ACCESS;
          addr_d   = PADDR;
          write_d  = PWRITE;
          wdata_d  = PWDATA;
          err_d    = addr_err;
          cnt_d    = 4'(WAIT_STATES);
          prdata_d = (!PWRITE && !addr_err) ? rd_word : '0;
        end else if (PSEL && PENABLE) begin
          proto_set = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          if (violation) begin
            state_d   = IDLE;
            prdata_d  = '0;
            cnt_d     = 4'd0;
            proto_set = 1'b1;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end else begin
          state_d  = IDLE;
          prdata_d = '0;
          mem_we   = write_q && !err_q;
        end
      end
      default: state_d = IDLE;
    endcase
    proto_err_d = proto_set ? 1'b1 : (clr_err ? 1'b0 : proto_err_q);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 4'd0;
      prdata_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      prdata_q    <= prdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign PREADY    = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign PSLVERR   = PREADY && err_q;
  assign PRDATA    = prdata_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed and randomized bench for apb_slave_mem
module tb_apb_slave_mem;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       sel_a, sel_b, penable, pwrite, clr_err;
  logic [7:0] paddr, pwdata;
  logic [7:0] prdata_a, prdata_b;
  logic       pready_a, pready_b, pslverr_a, pslverr_b, perr_a, perr_b;

  int total = 0;
  int bad = 0;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  always #5 PCLK = ~PCLK;

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(200), .WAIT_STATES(2)) dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(sel_a), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_a), .PREADY(pready_a),
    .PSLVERR(pslverr_a), .proto_err(perr_a), .clr_err(clr_err)
  );

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .DEPTH(256), .WAIT_STATES(0)) dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(sel_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata_b), .PREADY(pready_b),
    .PSLVERR(pslverr_b), .proto_err(perr_b), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_models();
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
  endtask

  task automatic idle();
    sel_a = 1'b0; sel_b = 1'b0; penable = 1'b0;
    @(posedge PCLK); @(negedge PCLK);
  endtask

  // One complete transfer on slave b (1) or a (0); returns at the negedge after completion
  task automatic xfer(input bit b, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input string tag);
    int         ws, dep, waits;
    bit         exp_err;
    logic [7:0] exp_rd;
    ws      = b ? 0 : 2;
    dep     = b ? 256 : 200;
    exp_err = (int'(a) >= dep);
    exp_rd  = (!wr && !exp_err) ? (b ? mem_b[a] : mem_a[a]) : 8'h00;
    sel_a = !b; sel_b = b; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge PCLK); @(negedge PCLK);
    penable = 1'b1;
    waits   = 0;
    while (!(b ? pready_b : pready_a) && waits < 20) begin
      chk({tag, "/hold_prdata"}, 32'(b ? prdata_b : prdata_a), 32'(exp_rd));
      chk({tag, "/wait_pslverr"}, 32'(b ? pslverr_b : pslverr_a), 32'd0);
      waits++;
      @(negedge PCLK);
    end
    chk({tag, "/waits"}, 32'(waits), 32'(ws));
    chk({tag, "/pslverr"}, 32'(b ? pslverr_b : pslverr_a), 32'(exp_err));
    chk({tag, "/prdata"}, 32'(b ? prdata_b : prdata_a), 32'(exp_rd));
    if (wr && !exp_err) begin
      if (b) mem_b[a] = d;
      else   mem_a[a] = d;
    end
    @(posedge PCLK); @(negedge PCLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         b, wr;
    logic [7:0] a, d;
    sel_a = 0; sel_b = 0; penable = 0; pwrite = 0; clr_err = 0; paddr = 0; pwdata = 0;
    clear_models();
    repeat (2) @(negedge PCLK);
    chk("rst/prdata", 32'(prdata_a), 32'd0);
    chk("rst/pready", 32'(pready_a), 32'd0);
    chk("rst/pslverr", 32'(pslverr_a), 32'd0);
    chk("rst/proto_err", 32'(perr_a), 32'd0);
    PRESETn = 1'b1;
    @(negedge PCLK);

    xfer(0, 1, 8'h10, 8'hA5, "t1w");
    idle();
    xfer(0, 0, 8'h10, 8'h00, "t1r");
    idle();

    xfer(0, 1, 8'h00, 8'h01, "t2w0");
    xfer(0, 1, 8'h01, 8'h02, "t2w1");
    xfer(0, 0, 8'h00, 8'h00, "t2r0");
    xfer(0, 0, 8'h01, 8'h00, "t2r1");
    idle();

    xfer(0, 1, 8'hC8, 8'h55, "t3w");
    xfer(0, 0, 8'hC8, 8'h00, "t3r");
    xfer(0, 0, 8'hC7, 8'h00, "t3r_c7");
    idle();

    xfer(1, 1, 8'hFF, 8'hFF, "t4w");
    xfer(1, 0, 8'hFF, 8'h00, "t4r");
    idle();

    // Write abort: drop PSEL while one wait cycle remains
    xfer(0, 1, 8'h30, 8'h11, "t5pre");
    idle();
    sel_a = 1; penable = 0; pwrite = 1; paddr = 8'h30; pwdata = 8'h3C;
    @(posedge PCLK); @(negedge PCLK);
    penable = 1;
    @(posedge PCLK); @(negedge PCLK);
    chk("t5w/pready_cnt1", 32'(pready_a), 32'd0);
    sel_a = 0; penable = 0;
    @(posedge PCLK); @(negedge PCLK);
    chk("t5w/proto_err", 32'(perr_a), 32'd1);
    chk("t5w/pready", 32'(pready_a), 32'd0);
    xfer(0, 0, 8'h30, 8'h00, "t5w_rb");
    idle();

    clr_err = 1;
    @(posedge PCLK); @(negedge PCLK);
    clr_err = 0;
    chk("t5/clr1", 32'(perr_a), 32'd0);

    // Read abort: address changes in the first ACCESS cycle
    sel_a = 1; penable = 0; pwrite = 0; paddr = 8'h10;
    @(posedge PCLK); @(negedge PCLK);
    penable = 1; paddr = 8'h11;
    @(posedge PCLK); @(negedge PCLK);
    chk("t5r/proto_err", 32'(perr_a), 32'd1);
    chk("t5r/pready", 32'(pready_a), 32'd0);
    chk("t5r/prdata", 32'(prdata_a), 32'd0);
    sel_a = 0; penable = 0;
    @(posedge PCLK); @(negedge PCLK);
    xfer(0, 0, 8'h10, 8'h00, "t5r_rb");
    idle();

    clr_err = 1;
    @(posedge PCLK); @(negedge PCLK);
    clr_err = 0;
    chk("t5/clr2", 32'(perr_a), 32'd0);

    // Access without setup coincident with clear: the set wins
    sel_a = 1; penable = 1; clr_err = 1;
    @(posedge PCLK); @(negedge PCLK);
    sel_a = 0; penable = 0; clr_err = 0;
    chk("t5/set_wins", 32'(perr_a), 32'd1);
    chk("t5/b_untouched", 32'(perr_b), 32'd0);
    @(posedge PCLK); @(negedge PCLK);
    chk("t5/sticky", 32'(perr_a), 32'd1);

    // Reset in the first wait cycle of a write
    sel_a = 1; penable = 0; pwrite = 1; paddr = 8'h20; pwdata = 8'h77;
    @(posedge PCLK); @(negedge PCLK);
    penable = 1;
    PRESETn = 0;
    #1;
    chk("t6/prdata", 32'(prdata_a), 32'd0);
    chk("t6/pready", 32'(pready_a), 32'd0);
    chk("t6/pslverr", 32'(pslverr_a), 32'd0);
    chk("t6/proto_err", 32'(perr_a), 32'd0);
    sel_a = 0; penable = 0;
    @(posedge PCLK); @(negedge PCLK);
    PRESETn = 1;
    clear_models();
    @(posedge PCLK); @(negedge PCLK);
    xfer(0, 0, 8'h20, 8'h00, "t6r20");
    xfer(0, 0, 8'h10, 8'h00, "t6r10");
    xfer(1, 0, 8'hFF, 8'h00, "t6rb");
    idle();

    for (int i = 0; i < 60; i++) begin
      b  = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(190, 255))
                                       : 8'($urandom_range(0, 15));
      d  = 8'($urandom);
      xfer(b, wr, a, d, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    chk("end/proto_err_a", 32'(perr_a), 32'd0);
    chk("end/proto_err_b", 32'(perr_b), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer (slave) for the two-slave APB subsystem; one instance sits behind each master select line (sel1 / sel2 wired to PSEL).
- Holds a DEPTH x DATA_WIDTH memory.
- Inserts a parameterised number of wait states and reports out-of-range accesses on PSLVERR.
- Detects master protocol violations mid-transfer, aborts them, and flags them in a sticky status bit.

Parameters:
- ADDR_WIDTH, 8: local address width; the slave uses PADDR[7:0], and bit 8 is decoded upstream into PSEL.
- DATA_WIDTH, 8: PWDATA/PRDATA width.
- DEPTH, 256: number of implemented words; addresses >= DEPTH are errors. Legal range 1..2^ADDR_WIDTH.
- WAIT_STATES, 0: number of ACCESS cycles with PREADY=0 before completion. Legal range 0..15.

Ports:
- PCLK, in, 1: APB clock.
- PRESETn, in, 1: asynchronous active-low reset.
- PSEL, in, 1: slave select.
- PENABLE, in, 1: access phase.
- PWRITE, in, 1: 1 = write, 0 = read.
- PADDR, in, ADDR_WIDTH: word address.
- PWDATA, in, DATA_WIDTH: write data.
- PRDATA, out, DATA_WIDTH: read data.
- PREADY, out, 1: transfer complete.
- PSLVERR, out, 1: transfer error; valid only while PREADY=1.
- proto_err, out, 1: sticky protocol-violation flag.
- clr_err, in, 1: synchronous clear of proto_err.

Behaviour:
- Reset: PRESETn is asynchronous, active-low; clock is PCLK.
  - Under reset: state=IDLE, PRDATA=0, proto_err=0, wait counter=0, latched addr/data/write=0, all memory words=0.
  - PREADY=0 and PSLVERR=0 while in IDLE.
- FSM states: IDLE, ACCESS.
  - IDLE -> ACCESS on the PCLK edge where PSEL=1 && PENABLE=0 (setup phase).
  - At that same edge the slave latches PADDR, PWRITE and PWDATA, loads cnt=WAIT_STATES, and computes err = (PADDR >= DEPTH).
  - For reads, PRDATA is loaded at that edge with mem[PADDR] when in range, else 0.
  - In IDLE, PSEL=1 && PENABLE=1 (access without setup) sets proto_err and the FSM stays in IDLE.
- ACCESS, per cycle:
  - PREADY = (cnt==0) (combinational from registers).
  - PSLVERR = PREADY && err.
  - If cnt!=0: decrement cnt and stay in ACCESS.
  - If cnt==0: the completion edge returns the FSM to IDLE.
  - On the completion edge of a write with !err: mem[addr] <= latched data.
  - An erroneous write never modifies memory. An erroneous read returns PRDATA=0.
- Latency:
  - Total transfer = 1 setup + (WAIT_STATES+1) access cycles.
  - WAIT_STATES=0 gives the minimum 2-cycle APB transfer.
- PRDATA:
  - Holds its value through ACCESS.
  - Cleared to 0 on the edge leaving ACCESS.
  - Stays 0 for writes.
- Back-to-back: the master's ACCESS->SETUP is seen as PSEL=1, PENABLE=0 in the cycle after completion. The slave is then in IDLE and accepts it with no bubble. A read directly after a write to the same address returns the new data.
- Protocol violations during ACCESS before completion:
  - Triggers: PSEL=0, PENABLE=0, or PADDR/PWRITE/PWDATA (write only) differing from the latched values.
  - Response: abort to IDLE, no memory update, PREADY stays 0, proto_err <= 1.
- proto_err:
  - Cleared only by reset or clr_err.
  - If clr_err and a new violation occur on the same edge, set wins.
- Reset asserted mid-transfer: immediate return to reset values and memory cleared. An in-flight write is not committed.
- Width rules: no address wrap. For DEPTH=2^ADDR_WIDTH the error compare is constant-false.

Decomposition:
- Package apb_pkg:
  - state enum {IDLE, ACCESS}.
  - APB_ADDR_W=9, APB_DATA_W=8.
  - Slave-select bit index SEL_BIT=8, shared with the master-side decode.
- Sub-module apb_slave_mem_array: DEPTH x DATA_WIDTH array with async clear, one write port (we, waddr, wdata), one combinational read port. The FSM, wait counter and checks stay in the top.

Test Plan (WAIT_STATES=2, DEPTH=200 unless noted):
1. Write 0xA5 to addr 0x10, then read 0x10 -> write shows 2 PREADY-low ACCESS cycles then PREADY=1, PSLVERR=0; read returns PRDATA=0xA5 in its completion cycle.
2. Back-to-back writes 0x01->0x00, 0x02->0x01, then back-to-back reads with no IDLE between -> each transfer is 4 cycles with no bubble; reads return 0x01 and 0x02.
3. Write 0x55 to 0xC8 (200), then read 0xC8 -> PSLVERR=1 with PREADY=1 on both; read PRDATA=0; memory unchanged (a read of 0xC7 still returns 0).
4. WAIT_STATES=0, DEPTH=256: write 0xFF to 0xFF then read it -> PREADY=1 in the first ACCESS cycle; readback 0xFF; PSLVERR never set.
5. During a write ACCESS with cnt=1, drop PSEL; then change PADDR mid-read; then pulse clr_err -> each abort leaves memory unmodified and proto_err=1; proto_err=0 after the clr_err edge.
6. Assert PRESETn low in the first wait cycle of a write of 0x77 to 0x20, release, read 0x20 -> all outputs 0 during reset; readback 0x00.
